pipe_issue_arbiter: RTL and testbench
=====================================

Name: pipe_issue_arbiter

Overview:
Instruction-issue scheduler that shares the single 8-bit instruction slot of the 4-register add/sub/and pipeline between two instruction requesters. Each requester pushes into a private 4-entry FIFO via valid/ready. Each enabled cycle, a round-robin arbiter pops one instruction and presents it registered on issue_inst. When nothing is pending, it issues NOP (8'h00). It sits directly in front of the pipeline's inst input; issue_en is driven by the same signal as the pipeline's __START__.

Parameters:
DEPTH, 4, entries per requester FIFO; power of two, at least 2.
AW, 2, log2(DEPTH); pointer width. Occupancy counters are AW+1 bits.
CW, 8, width of per-requester issued-instruction counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
issue_en  in  1  pipeline advance enable; tie to pipeline __START__
req0_valid  in  1  requester 0 has an instruction
req0_inst  in  8  requester 0 instruction {op[7:6],rs1[5:4],rs2[3:2],rd[1:0]}
req0_ready  out  1  FIFO0 not full
req1_valid  in  1  requester 1 has an instruction
req1_inst  in  8  requester 1 instruction
req1_ready  out  1  FIFO1 not full
issue_inst  out  8  registered instruction to pipeline inst input
issue_grant  out  2  registered one-hot source of issue_inst; 2'b00 = NOP filler
issue_cnt0  out  CW  instructions issued from requester 0 (wraps)
issue_cnt1  out  CW  instructions issued from requester 1 (wraps)
fifo0_cnt  out  AW+1  FIFO0 occupancy
fifo1_cnt  out  AW+1  FIFO1 occupancy

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - issue_inst=8'h00, issue_grant=2'b00, issue_cnt0/1=0.
  - Both FIFOs emptied: pointers=0, fifoN_cnt=0.
  - rr_last=1, so requester 0 wins the first tie.
  - rst overrides every push, pop and issue in that cycle. Reset mid-operation discards all queued instructions.
- Ready: reqN_ready = (fifoN_cnt != DEPTH).
  - Combinational from occupancy only; it does not look ahead at a same-cycle pop.
  - Ready is independent of issue_en.
- Push: when reqN_valid && reqN_ready, write reqN_inst at the write pointer.
  - The write pointer increments modulo DEPTH (wrap from DEPTH-1 to 0).
  - Pushes are accepted whether or not issue_en is asserted.
- Arbitration, evaluated only when issue_en=1, using pre-push occupancy:
  - Neither FIFO non-empty: issue_inst<=8'h00, issue_grant<=2'b00, no pop.
  - Exactly one FIFO non-empty: that FIFO wins.
  - Both non-empty: the FIFO other than rr_last wins.
  - Winner N: issue_inst<=head of FIFO N, issue_grant<=one-hot N, pop FIFO N (read pointer +1 mod DEPTH), issue_cntN+=1 (wraps at 2^CW), rr_last<=N.
  - rr_last updates only on a real grant; NOP cycles leave it unchanged.
- issue_en=0:
  - issue_inst, issue_grant, rr_last and the counters hold.
  - No pop occurs; pushes continue.
  - This holds the pipeline's inst stable while the pipeline is frozen.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged and both pointers advance.
  - A full FIFO (cnt=DEPTH) shows ready=0, so a pop that cycle does not allow a same-cycle push.
- Latency:
  - An instruction pushed at edge N is poppable from edge N+1.
  - It appears on issue_inst at edge N+1 at the earliest: entry visible after N, issued at N+1.
  - Exact rule: with an empty FIFO, a push at cycle t is issued at the edge ending cycle t+1.
- Ordering: per-requester order is strictly FIFO; instructions are never dropped or duplicated.
- Fairness: with both FIFOs continuously non-empty and issue_en=1, grants alternate 0,1,0,1,…
- Hazards are not the arbiter's concern; the pipeline forwards. Opcodes pass through unmodified, including op=00 NOP from a requester, which is counted as a grant.

Test Plan:
- Reset then idle with issue_en=1 for 5 cycles -> issue_inst=8'h00, issue_grant=00, req0/1_ready=1, counters 0.
- Push 8'h41 on req0 at cycle 1, issue_en=1 -> issue_inst=8'h41, grant=01 at the edge ending cycle 2; issue_cnt0=1; next cycle issue_inst=8'h00.
- Preload FIFO0 {8'h41,8'h46} and FIFO1 {8'h9B,8'hC3} with issue_en=0, then issue_en=1 -> issue_inst sequence 41,9B,46,C3,00 with grants 01,10,01,10,00; cnt0=cnt1=2.
- Push 5 on req0 with issue_en=0 -> first 4 accepted (fifo0_cnt=4), req0_ready=0 on the 5th; then one issue cycle -> cnt=3 and ready=1. Repeat 3 fill/drain rounds to exercise pointer wrap; data order preserved.
- issue_en toggled 1,0,0,1 with both FIFOs loaded -> issue_inst/grant held during the 0 cycles; alternation resumes from the correct rr_last.
- Assert rst with 3 queued entries and issue_inst=8'h46 -> next edge all outputs 0, fifo counts 0, queued entries never issued; first post-reset tie grants req0.

Source files
------------

// File: rtl/pipe_issue_arbiter.sv
// pipe_issue_arbiter: two small requester FIFOs sharing one registered
// round-robin issue slot in front of the 8-bit add/sub/and pipeline.
module pipe_issue_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_en,
  input  logic          req0_valid,
  input  logic [7:0]    req0_inst,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_inst,
  output logic          req1_ready,
  output logic [7:0]    issue_inst,
  output logic [1:0]    issue_grant,
  output logic [CW-1:0] issue_cnt0,
  output logic [CW-1:0] issue_cnt1,
  output logic [AW:0]   fifo0_cnt,
  output logic [AW:0]   fifo1_cnt
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem0 [DEPTH];
  logic [7:0]    mem1 [DEPTH];
  logic [AW-1:0] wp0;
  logic [AW-1:0] rp0;
  logic [AW-1:0] wp1;
  logic [AW-1:0] rp1;
  logic          rr_last;
  logic          push0;
  logic          push1;
  logic          ne0;
  logic          ne1;
  logic          pop0;
  logic          pop1;

  assign req0_ready = (fifo0_cnt != FULL);
  assign req1_ready = (fifo1_cnt != FULL);
  assign push0 = req0_valid && req0_ready;
  assign push1 = req1_valid && req1_ready;
  assign ne0 = (fifo0_cnt != '0);
  assign ne1 = (fifo1_cnt != '0);

  // Tie goes to the requester that did not win last.
  assign pop0 = issue_en && ne0 && (!ne1 || rr_last);
  assign pop1 = issue_en && ne1 && (!ne0 || !rr_last);

  always_ff @(posedge clk) begin
    if (!rst && push0) mem0[wp0] <= req0_inst;
    if (!rst && push1) mem1[wp1] <= req1_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp0         <= '0;
      rp0         <= '0;
      wp1         <= '0;
      rp1         <= '0;
      fifo0_cnt   <= '0;
      fifo1_cnt   <= '0;
      rr_last     <= 1'b1;
      issue_inst  <= 8'h00;
      issue_grant <= 2'b00;
      issue_cnt0  <= '0;
      issue_cnt1  <= '0;
    end else begin
      if (push0) wp0 <= wp0 + AW'(1);
      if (push1) wp1 <= wp1 + AW'(1);
      if (pop0) rp0 <= rp0 + AW'(1);
      if (pop1) rp1 <= rp1 + AW'(1);
      fifo0_cnt <= fifo0_cnt + (AW+1)'(push0)
                 - (AW+1)'(pop0);
      fifo1_cnt <= fifo1_cnt + (AW+1)'(push1)
                 - (AW+1)'(pop1);
      if (issue_en) begin
        unique case (1'b1)
          pop0: begin
            issue_inst  <= mem0[rp0];
            issue_grant <= 2'b01;
            issue_cnt0  <= issue_cnt0 + CW'(1);
            rr_last     <= 1'b0;
          end
          pop1: begin
            issue_inst  <= mem1[rp1];
            issue_grant <= 2'b10;
            issue_cnt1  <= issue_cnt1 + CW'(1);
            rr_last     <= 1'b1;
          end
          default: begin
            issue_inst  <= 8'h00;
            issue_grant <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Self-checking bench for pipe_issue_arbiter: reference queues act as
// scoreboard, plus directed scenario checks against fixed values.
module tb_pipe_issue_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_en = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_inst = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_inst = 8'h00;
  logic       req1_ready;
  logic [7:0] issue_inst;
  logic [1:0] issue_grant;
  logic [7:0] issue_cnt0;
  logic [7:0] issue_cnt1;
  logic [2:0] fifo0_cnt;
  logic [2:0] fifo1_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  logic       m_rr = 1'b1;
  logic [7:0] m_inst = 8'h00;
  logic [1:0] m_grant = 2'b00;
  logic [7:0] m_c0 = 8'h00;
  logic [7:0] m_c1 = 8'h00;

  pipe_issue_arbiter #(.DEPTH(4), .AW(2), .CW(8)) dut (
    .clk(clk),
    .rst(rst),
    .issue_en(issue_en),
    .req0_valid(req0_valid),
    .req0_inst(req0_inst),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_inst(req1_inst),
    .req1_ready(req1_ready),
    .issue_inst(issue_inst),
    .issue_grant(issue_grant),
    .issue_cnt0(issue_cnt0),
    .issue_cnt1(issue_cnt1),
    .fifo0_cnt(fifo0_cnt),
    .fifo1_cnt(fifo1_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted pushes queue up, grants pop and compare.
  always @(posedge clk) begin
    logic v0s, v1s, ens, rsts;
    logic [7:0] d0s, d1s;
    int n0, n1;
    v0s = req0_valid; v1s = req1_valid;
    d0s = req0_inst;  d1s = req1_inst;
    ens = issue_en;   rsts = rst;
    n0 = sb0.size();  n1 = sb1.size();
    if (rsts) begin
      sb0.delete(); sb1.delete();
      m_rr = 1'b1; m_inst = 8'h00; m_grant = 2'b00;
      m_c0 = 8'h00; m_c1 = 8'h00;
    end else begin
      checks++;
      if (req0_ready !== (n0 != 4) || req1_ready !== (n1 != 4)) begin
        errors++;
        $display("FAIL sb_ready got %b%b want %b%b",
                 req0_ready, req1_ready, n0 != 4, n1 != 4);
      end
      if (ens) begin
        if (n0 > 0 && (n1 == 0 || m_rr)) begin
          m_inst = sb0.pop_front(); m_grant = 2'b01;
          m_c0 = m_c0 + 8'd1; m_rr = 1'b0;
        end else if (n1 > 0) begin
          m_inst = sb1.pop_front(); m_grant = 2'b10;
          m_c1 = m_c1 + 8'd1; m_rr = 1'b1;
        end else begin
          m_inst = 8'h00; m_grant = 2'b00;
        end
      end
      if (v0s && n0 < 4) sb0.push_back(d0s);
      if (v1s && n1 < 4) sb1.push_back(d1s);
    end
    #2;
    checks++;
    if (issue_inst !== m_inst || issue_grant !== m_grant) begin
      errors++;
      $display("FAIL sb_issue got %h/%b want %h/%b",
               issue_inst, issue_grant, m_inst, m_grant);
    end
    checks++;
    if (issue_cnt0 !== m_c0 || issue_cnt1 !== m_c1) begin
      errors++;
      $display("FAIL sb_cnt got %0d/%0d want %0d/%0d",
               issue_cnt0, issue_cnt1, m_c0, m_c1);
    end
    checks++;
    if (fifo0_cnt !== 3'(sb0.size()) ||
        fifo1_cnt !== 3'(sb1.size())) begin
      errors++;
      $display("FAIL sb_occ got %0d/%0d want %0d/%0d",
               fifo0_cnt, fifo1_cnt, sb0.size(), sb1.size());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; issue_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; issue_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (issue_inst !== 8'h00 || issue_grant !== 2'b00 ||
          req0_ready !== 1'b1 || req1_ready !== 1'b1 ||
          issue_cnt0 !== 8'd0 || issue_cnt1 !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle got %h/%b rdy %b%b cnt %0d/%0d want 00/00 rdy 11 cnt 0/0",
                 issue_inst, issue_grant, req0_ready, req1_ready,
                 issue_cnt0, issue_cnt1);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    issue_en = 1'b1; req0_valid = 1'b1; req0_inst = 8'h41;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (issue_grant !== 2'b00) begin
      errors++;
      $display("FAIL single_early got %b want 00", issue_grant);
    end
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h41 || issue_grant !== 2'b01 ||
        issue_cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL single_issue got %h/%b cnt %0d want 41/01 cnt 1",
               issue_inst, issue_grant, issue_cnt0);
    end
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h00 || issue_grant !== 2'b00) begin
      errors++;
      $display("FAIL single_nop got %h/%b want 00/00",
               issue_inst, issue_grant);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] ei [5] = '{8'h41, 8'h9B, 8'h46, 8'hC3, 8'h00};
    logic [1:0] eg [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_reset();
    req0_valid = 1'b1; req0_inst = 8'h41;
    req1_valid = 1'b1; req1_inst = 8'h9B;
    @(negedge clk);
    req0_inst = 8'h46; req1_inst = 8'hC3;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; issue_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (issue_inst !== ei[k] || issue_grant !== eg[k]) begin
        errors++;
        $display("FAIL alt_%0d got %h/%b want %h/%b",
                 k, issue_inst, issue_grant, ei[k], eg[k]);
      end
    end
    checks++;
    if (issue_cnt0 !== 8'd2 || issue_cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL alt_cnt got %0d/%0d want 2/2",
               issue_cnt0, issue_cnt1);
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] first;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      issue_en = 1'b0;
      first = 8'(r * 16 + 1);
      for (int i = 0; i < 5; i++) begin
        req0_valid = 1'b1; req0_inst = 8'(r * 16 + i + 1);
        checks++;
        if (req0_ready !== (i < 4)) begin
          errors++;
          $display("FAIL fill_ready r%0d i%0d got %b want %b",
                   r, i, req0_ready, i < 4);
        end
        @(negedge clk);
      end
      req0_valid = 1'b0;
      checks++;
      if (fifo0_cnt !== 3'd4) begin
        errors++;
        $display("FAIL fill_full r%0d got %0d want 4", r, fifo0_cnt);
      end
      issue_en = 1'b1;
      @(negedge clk);
      issue_en = 1'b0;
      checks++;
      if (fifo0_cnt !== 3'd3 || req0_ready !== 1'b1 ||
          issue_inst !== first) begin
        errors++;
        $display("FAIL fill_pop r%0d got cnt %0d rdy %b inst %h want 3 1 %h",
                 r, fifo0_cnt, req0_ready, issue_inst, first);
      end
      issue_en = 1'b1;
      repeat (3) @(negedge clk);
      issue_en = 1'b0;
      checks++;
      if (fifo0_cnt !== 3'd0 || issue_inst !== 8'(r * 16 + 4)) begin
        errors++;
        $display("FAIL fill_drain r%0d got cnt %0d inst %h want 0 %h",
                 r, fifo0_cnt, issue_inst, 8'(r * 16 + 4));
      end
    end
  endtask

  task automatic test_hold();
    logic       ep [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ei [6] = '{8'h41, 8'h41, 8'h41, 8'h9B, 8'h46, 8'hC3};
    logic [1:0] eg [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req0_valid = 1'b1; req0_inst = 8'h41;
    req1_valid = 1'b1; req1_inst = 8'h9B;
    @(negedge clk);
    req0_inst = 8'h46; req1_inst = 8'hC3;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    issue_en = ep[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (issue_inst !== ei[k] || issue_grant !== eg[k]) begin
        errors++;
        $display("FAIL hold_%0d got %h/%b want %h/%b",
                 k, issue_inst, issue_grant, ei[k], eg[k]);
      end
      if (k < 5) issue_en = ep[k+1];
    end
    issue_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_inst = 8'h46;
    req1_valid = 1'b1; req1_inst = 8'h9B;
    @(negedge clk);
    req0_inst = 8'h47; req1_valid = 1'b0;
    @(negedge clk);
    req0_inst = 8'h48;
    @(negedge clk);
    req0_valid = 1'b0; issue_en = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h46 || issue_grant !== 2'b01) begin
      errors++;
      $display("FAIL mid_pre got %h/%b want 46/01",
               issue_inst, issue_grant);
    end
    issue_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h00 || issue_grant !== 2'b00 ||
        fifo0_cnt !== 3'd0 || fifo1_cnt !== 3'd0 ||
        issue_cnt0 !== 8'd0 || issue_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst got %h/%b occ %0d/%0d cnt %0d/%0d want all 0",
               issue_inst, issue_grant, fifo0_cnt, fifo1_cnt,
               issue_cnt0, issue_cnt1);
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_inst = 8'h11;
    req1_valid = 1'b1; req1_inst = 8'h22;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; issue_en = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h11 || issue_grant !== 2'b01) begin
      errors++;
      $display("FAIL mid_tie got %h/%b want 11/01",
               issue_inst, issue_grant);
    end
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h22 || issue_grant !== 2'b10) begin
      errors++;
      $display("FAIL mid_second got %h/%b want 22/10",
               issue_inst, issue_grant);
    end
    @(negedge clk);
    checks++;
    if (issue_inst !== 8'h00 || issue_grant !== 2'b00) begin
      errors++;
      $display("FAIL mid_empty got %h/%b want 00/00",
               issue_inst, issue_grant);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_fill_wrap();
    test_hold();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
